// File: rtl/uart_rx_fifo_pkg.sv
// Shared widths and entry layout for the UART receive FIFO.
// Build option: UART_RX_FIFO_ERRTAG_EN stores parity/framing tags per entry.
package uart_rx_fifo_pkg;

   localparam int RX_DATA_W = 8;
   localparam int ERRTAG_W  = 2;

`ifdef UART_RX_FIFO_ERRTAG_EN
   localparam int ENTRY_W = RX_DATA_W + ERRTAG_W;
`else
   localparam int ENTRY_W = RX_DATA_W;
`endif

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver/APB-facing signal bundle of the UART receive FIFO.
// master = receiver + APB side, slave = the FIFO itself.
interface uart_rx_fifo_if
   import uart_rx_fifo_pkg::*;
#(
   parameter int DEPTH = 16
);

   logic                     fifo_write_n;
   logic [RX_DATA_W-1:0]     rx_byte;
   logic                     parity_err_in;
   logic                     frame_err_in;
   logic                     read_rx_byte;
   logic [RX_DATA_W-1:0]     rx_data;
   logic                     rx_ready;
   logic                     rx_full;
   logic                     rx_afull;
   logic [ptr_w(DEPTH)-1:0]  rx_level;
   logic                     overflow;
   logic                     rx_perr;
   logic                     rx_ferr;

   modport master (
      output fifo_write_n, rx_byte, parity_err_in,
             frame_err_in, read_rx_byte,
      input  rx_data, rx_ready, rx_full, rx_afull,
             rx_level, overflow, rx_perr, rx_ferr
   );

   modport slave (
      input  fifo_write_n, rx_byte, parity_err_in,
             frame_err_in, read_rx_byte,
      output rx_data, rx_ready, rx_full, rx_afull,
             rx_level, overflow, rx_perr, rx_ferr
   );

endinterface

// File: rtl/uart_rx_fifo_ram.sv
// FIFO storage: synchronous write port, asynchronous read port.
// Contents are deliberately not reset; pointers gate visibility.
module uart_rx_fifo_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures receiver bytes, presents head to APB.
// Build option: UART_RX_FIFO_ERRTAG_EN adds per-entry parity/frame tags.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int AFULL_THRESH = 12
) (
   input  logic          clk,
   input  logic          reset_n,
   uart_rx_fifo_if.slave bus
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;

   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      level;
   logic [ENTRY_W-1:0] wdata;
   logic [ENTRY_W-1:0] rdata;
   logic               wr;
   logic               empty;
   logic               full;
   logic               pop;
   logic               accept;
   logic               ovf;

   assign wr    = ~bus.fifo_write_n;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
                & (wr_ptr[AW] != rd_ptr[AW]);
   assign level = wr_ptr - rd_ptr;

   assign pop    = bus.read_rx_byte & ~empty;
   // a same-cycle pop frees the slot, so a full FIFO still accepts
   assign accept = wr & (~full | pop);

`ifdef UART_RX_FIFO_ERRTAG_EN
   assign wdata = {bus.frame_err_in, bus.parity_err_in, bus.rx_byte};
   assign bus.rx_perr = ~empty & rdata[RX_DATA_W];
   assign bus.rx_ferr = ~empty & rdata[RX_DATA_W+1];
`else
   logic unused_tags;
   assign unused_tags = bus.frame_err_in ^ bus.parity_err_in;
   assign wdata       = bus.rx_byte;
   assign bus.rx_perr = 1'b0;
   assign bus.rx_ferr = 1'b0;
`endif

   uart_rx_fifo_ram #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_ram (
      .clk   (clk),
      .we    (accept),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (wdata),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PW'(1);
         if (pop)    rd_ptr <= rd_ptr + PW'(1);
         if (wr && full && !pop)    ovf <= 1'b1;
         else if (bus.read_rx_byte) ovf <= 1'b0;
      end
   end

   assign bus.rx_data  = empty ? '0 : rdata[RX_DATA_W-1:0];
   assign bus.rx_ready = ~empty;
   assign bus.rx_full  = full;
   assign bus.rx_afull = (level >= PW'(AFULL_THRESH));
   assign bus.rx_level = level;
   assign bus.overflow = ovf;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16, AFULL_THRESH=12).
module tb_uart_rx_fifo;

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_bad;

   uart_rx_fifo_if #(.DEPTH(16)) bus ();

   uart_rx_fifo #(
      .DEPTH        (16),
      .AFULL_THRESH (12)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [15:0] got,
                      input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input bit w, input logic [7:0] b,
                       input bit pe, input bit fe, input bit rd);
      bus.fifo_write_n  = ~w;
      bus.rx_byte       = b;
      bus.parity_err_in = pe;
      bus.frame_err_in  = fe;
      bus.read_rx_byte  = rd;
      @(posedge clk);
      #1;
      bus.fifo_write_n  = 1'b1;
      bus.parity_err_in = 1'b0;
      bus.frame_err_in  = 1'b0;
      bus.read_rx_byte  = 1'b0;
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_ready"}, 16'(bus.rx_ready), 16'd0);
      chk({tag, "_data"},  16'(bus.rx_data),  16'd0);
      chk({tag, "_level"}, 16'(bus.rx_level), 16'd0);
      chk({tag, "_ovf"},   16'(bus.overflow), 16'd0);
      chk({tag, "_full"},  16'(bus.rx_full),  16'd0);
      chk({tag, "_afull"}, 16'(bus.rx_afull), 16'd0);
   endtask

   logic [7:0] q[$];
   logic [7:0] got_last;
   logic [7:0] rb;
   bit         mw, mr, mpop, movf;
   int         op;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      bus.fifo_write_n  = 1'b1;
      bus.rx_byte       = '0;
      bus.parity_err_in = 1'b0;
      bus.frame_err_in  = 1'b0;
      bus.read_rx_byte  = 1'b0;
      reset_n = 1'b0;
      #12;
      idle_chk("rst");
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: single byte in, single byte out
      step(1, 8'hA5, 0, 0, 0);
      chk("t1_ready", 16'(bus.rx_ready), 16'd1);
      chk("t1_data",  16'(bus.rx_data),  16'h00A5);
      chk("t1_level", 16'(bus.rx_level), 16'd1);
      step(0, 8'h00, 0, 0, 1);
      chk("t1_pop_ready", 16'(bus.rx_ready), 16'd0);
      chk("t1_pop_data",  16'(bus.rx_data),  16'd0);

      // 2: fill, overflow, drain
      for (int i = 0; i < 16; i++) begin
         step(1, 8'(i), 0, 0, 0);
         chk("t2_afull", 16'(bus.rx_afull), 16'((i + 1) >= 12));
      end
      chk("t2_full",  16'(bus.rx_full),  16'd1);
      chk("t2_level", 16'(bus.rx_level), 16'd16);
      chk("t2_ovf0",  16'(bus.overflow), 16'd0);
      step(1, 8'hEE, 0, 0, 0);
      chk("t2_ovf",     16'(bus.overflow), 16'd1);
      chk("t2_ovf_lvl", 16'(bus.rx_level), 16'd16);
      for (int i = 0; i < 16; i++) begin
         chk("t2_pop_data", 16'(bus.rx_data), 16'(i));
         step(0, 8'h00, 0, 0, 1);
         chk("t2_pop_lvl", 16'(bus.rx_level), 16'(15 - i));
         if (i == 0) chk("t2_ovf_clr", 16'(bus.overflow), 16'd0);
      end
      idle_chk("t2_end");

      // 3: write + pop on full
      for (int i = 0; i < 16; i++) step(1, 8'(8'h80 + i), 0, 0, 0);
      step(1, 8'h55, 0, 0, 1);
      chk("t3_ovf",   16'(bus.overflow), 16'd0);
      chk("t3_level", 16'(bus.rx_level), 16'd16);
      chk("t3_head",  16'(bus.rx_data),  16'h0081);
      got_last = '0;
      for (int i = 0; i < 16; i++) begin
         got_last = bus.rx_data;
         step(0, 8'h00, 0, 0, 1);
      end
      chk("t3_last", 16'(got_last), 16'h0055);
      idle_chk("t3_end");

      // 4: pops on empty
      step(0, 8'h00, 0, 0, 1);
      idle_chk("t4_lone");
      step(1, 8'h3C, 0, 0, 1);
      chk("t4_level", 16'(bus.rx_level), 16'd1);
      chk("t4_data",  16'(bus.rx_data),  16'h003C);
      chk("t4_ovf",   16'(bus.overflow), 16'd0);
      step(0, 8'h00, 0, 0, 1);
      chk("t4_drain", 16'(bus.rx_level), 16'd0);

      // 5: random interleave against a queue model
      q.delete();
      movf = 1'b0;
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 2);
         mw = (op != 1);
         mr = (op != 0);
         rb = 8'($urandom);
         chk("t5_data",  16'(bus.rx_data),
             (q.size() > 0) ? 16'(q[0]) : 16'd0);
         chk("t5_level", 16'(bus.rx_level), 16'(q.size()));
         step(mw, rb, 0, 0, mr);
         mpop = mr && (q.size() > 0);
         if (mw && q.size() == 16 && !mpop) movf = 1'b1;
         else if (mr) movf = 1'b0;
         if (mpop) void'(q.pop_front());
         if (mw && (q.size() < 16)) q.push_back(rb);
         chk("t5_ovf", 16'(bus.overflow), 16'(movf));
      end
      for (int i = 0; i < 6; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
      bus.fifo_write_n = 1'b0;
      bus.rx_byte      = 8'h99;
      #3;
      reset_n = 1'b0;
      #1;
      idle_chk("t5_rst");
      @(posedge clk);
      #1;
      bus.fifo_write_n = 1'b1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      idle_chk("t5_post");

      // 6: error tags
      step(1, 8'h11, 1, 0, 0);
      step(1, 8'h22, 0, 1, 0);
      chk("t6_head", 16'(bus.rx_data), 16'h0011);
`ifdef UART_RX_FIFO_ERRTAG_EN
      chk("t6_perr0", 16'(bus.rx_perr), 16'd1);
      chk("t6_ferr0", 16'(bus.rx_ferr), 16'd0);
      step(0, 8'h00, 0, 0, 1);
      chk("t6_perr1", 16'(bus.rx_perr), 16'd0);
      chk("t6_ferr1", 16'(bus.rx_ferr), 16'd1);
`else
      chk("t6_perr0", 16'(bus.rx_perr), 16'd0);
      chk("t6_ferr0", 16'(bus.rx_ferr), 16'd0);
      step(0, 8'h00, 0, 0, 1);
      chk("t6_perr1", 16'(bus.rx_perr), 16'd0);
      chk("t6_ferr1", 16'(bus.rx_ferr), 16'd0);
`endif
      chk("t6_data1", 16'(bus.rx_data), 16'h0022);
      step(0, 8'h00, 0, 0, 1);
      chk("t6_perr2", 16'(bus.rx_perr), 16'd0);
      chk("t6_ferr2", 16'(bus.rx_ferr), 16'd0);
      idle_chk("t6_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
